// File: rtl/spi_flash_responder.sv
// SPI mode-0 target emulating a serial flash (READ 0x03, RDSR 0x05) in front of a
// 1-cycle-latency byte memory. SPI inputs are asynchronous and oversampled on clk.
module spi_flash_responder #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter logic [7:0]  STATUS_BYTE = 8'h00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  i_RESET,
    input  logic                  i_SPI_CLK,
    input  logic                  i_SPI_CS,
    input  logic                  i_SPI_MOSI,
    output logic                  o_SPI_MISO,
    output logic                  o_SPI_MISO_OE,
    output logic [ADDR_WIDTH-1:0] o_MEM_ADDR,
    output logic                  o_MEM_RD,
    input  logic [7:0]            i_MEM_DATA,
    output logic                  o_BUSY,
    output logic                  o_CMD_ERR
);

    localparam int unsigned CMD_BITS  = 8;
    localparam int unsigned ADDR_BITS = 24;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_STAT   = 3'd5;
    localparam logic [2:0] S_IGNORE = 3'd6;

    // Input synchronizers plus one extra SCK sample for edge detection
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_d;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise_c, sck_fall_c;

    always_ff @(posedge clk or posedge i_RESET) begin
        if (i_RESET) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_SPI_CLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_SPI_CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
            sck_d     <= sck_s;
        end
    end

    assign sck_s      = sck_sync[SYNC_STAGES-1];
    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign sck_rise_c = sck_s & ~sck_d;
    assign sck_fall_c = ~sck_s & sck_d;

    logic [2:0]            state_q, state_nx;
    logic [4:0]            bit_cnt_q, bit_cnt_nx;
    logic [2:0]            out_cnt_q, out_cnt_nx;
    logic [22:0]           in_sh_q, in_sh_nx;
    logic [7:0]            out_sh_q, out_sh_nx;
    logic [7:0]            pf_q, pf_nx;
    logic                  rd_q, rd_nx;
    logic                  miso_nx, oe_nx, mem_rd_nx, busy_nx, err_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [23:0]           in_word_c;
    logic [7:0]            src_c;

    always_ff @(posedge clk or posedge i_RESET) begin
        if (i_RESET) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            out_cnt_q     <= '0;
            in_sh_q       <= '0;
            out_sh_q      <= '0;
            pf_q          <= '0;
            rd_q          <= 1'b0;
            o_SPI_MISO    <= 1'b0;
            o_SPI_MISO_OE <= 1'b0;
            o_MEM_ADDR    <= '0;
            o_MEM_RD      <= 1'b0;
            o_BUSY        <= 1'b0;
            o_CMD_ERR     <= 1'b0;
        end else begin
            state_q       <= state_nx;
            bit_cnt_q     <= bit_cnt_nx;
            out_cnt_q     <= out_cnt_nx;
            in_sh_q       <= in_sh_nx;
            out_sh_q      <= out_sh_nx;
            pf_q          <= pf_nx;
            rd_q          <= rd_nx;
            o_SPI_MISO    <= miso_nx;
            o_SPI_MISO_OE <= oe_nx;
            o_MEM_ADDR    <= addr_nx;
            o_MEM_RD      <= mem_rd_nx;
            o_BUSY        <= busy_nx;
            o_CMD_ERR     <= err_nx;
        end
    end

    always_comb begin
        state_nx   = state_q;
        bit_cnt_nx = bit_cnt_q;
        out_cnt_nx = out_cnt_q;
        in_sh_nx   = in_sh_q;
        out_sh_nx  = out_sh_q;
        pf_nx      = pf_q;
        rd_nx      = o_MEM_RD;
        miso_nx    = o_SPI_MISO;
        addr_nx    = o_MEM_ADDR;
        mem_rd_nx  = 1'b0;
        err_nx     = 1'b0;
        in_word_c  = {in_sh_q, mosi_s};
        src_c      = (state_q == S_STAT) ? STATUS_BYTE : pf_q;

        // Read data arrives the cycle after the strobe, even if CS has since risen
        if (rd_q) begin
            pf_nx = i_MEM_DATA;
        end

        if (state_q != S_IDLE && cs_s) begin
            state_nx = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!cs_s) begin
                        state_nx   = S_CMD;
                        bit_cnt_nx = '0;
                        in_sh_nx   = '0;
                    end
                end
                S_CMD: begin
                    if (sck_rise_c) begin
                        in_sh_nx   = in_word_c[22:0];
                        bit_cnt_nx = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
                            bit_cnt_nx = '0;
                            out_cnt_nx = '0;
                            case (in_word_c[7:0])
                                8'h03:   state_nx = S_ADDR;
                                8'h05:   state_nx = S_STAT;
                                default: begin
                                    state_nx = S_IGNORE;
                                    err_nx   = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (sck_rise_c) begin
                        in_sh_nx   = in_word_c[22:0];
                        bit_cnt_nx = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
                            addr_nx    = ADDR_WIDTH'(in_word_c);
                            mem_rd_nx  = 1'b1;
                            out_cnt_nx = '0;
                            state_nx   = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (rd_q) begin
                        state_nx = S_DATA;
                    end
                end
                S_DATA, S_STAT: begin
                    if (sck_fall_c) begin
                        // Byte boundary: drive MSB of the next byte straight from its source
                        if (out_cnt_q == 3'd0) begin
                            miso_nx   = src_c[7];
                            out_sh_nx = {src_c[6:0], 1'b0};
                        end else begin
                            miso_nx   = out_sh_q[7];
                            out_sh_nx = {out_sh_q[6:0], 1'b0};
                        end
                        out_cnt_nx = out_cnt_q + 3'd1;
                        if (out_cnt_q == 3'd7 && state_q == S_DATA) begin
                            addr_nx   = o_MEM_ADDR + ADDR_WIDTH'(1);
                            mem_rd_nx = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        oe_nx   = (state_nx == S_DATA) || (state_nx == S_STAT);
        busy_nx = (state_nx != S_IDLE);
        if (!oe_nx) begin
            miso_nx = 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: bit-banged SPI host, behavioural
// 1-cycle-latency memory, table of transactions plus hand-written corner cases.
module tb_spi_flash_responder;

    localparam int unsigned AW = 16;
    localparam int unsigned H  = 8;

    logic          clk = 1'b0;
    logic          i_RESET;
    logic          i_SPI_CLK, i_SPI_CS, i_SPI_MOSI;
    logic          o_SPI_MISO, o_SPI_MISO_OE;
    logic [AW-1:0] o_MEM_ADDR;
    logic          o_MEM_RD;
    logic [7:0]    i_MEM_DATA;
    logic          o_BUSY, o_CMD_ERR;

    spi_flash_responder #(.ADDR_WIDTH(AW), .STATUS_BYTE(8'h5A), .SYNC_STAGES(2)) dut (
        .clk(clk), .i_RESET(i_RESET),
        .i_SPI_CLK(i_SPI_CLK), .i_SPI_CS(i_SPI_CS), .i_SPI_MOSI(i_SPI_MOSI),
        .o_SPI_MISO(o_SPI_MISO), .o_SPI_MISO_OE(o_SPI_MISO_OE),
        .o_MEM_ADDR(o_MEM_ADDR), .o_MEM_RD(o_MEM_RD), .i_MEM_DATA(i_MEM_DATA),
        .o_BUSY(o_BUSY), .o_CMD_ERR(o_CMD_ERR)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    always @(posedge clk) if (o_MEM_RD) i_MEM_DATA <= mem[o_MEM_ADDR];

    // Monitors sample on the falling clk edge
    logic [15:0] rd_log [$];
    int err_cnt = 0, oe_cnt = 0, double_rd = 0;
    logic rd_prev = 1'b0;
    always @(negedge clk) begin
        if (o_MEM_RD) rd_log.push_back(o_MEM_ADDR);
        if (o_MEM_RD && rd_prev) double_rd++;
        rd_prev = o_MEM_RD;
        if (o_CMD_ERR) err_cnt++;
        if (o_SPI_MISO_OE) oe_cnt++;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sck_bit(input logic b, output logic r);
        i_SPI_MOSI = b;
        wait_clk(H);
        r = o_SPI_MISO;
        i_SPI_CLK = 1'b1;
        wait_clk(H);
        i_SPI_CLK = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        rx = '0;
        for (int i = 7; i >= 0; i--) begin
            sck_bit(tx[i], r);
            rx = {rx[6:0], r};
        end
    endtask

    task automatic cs_begin();
        i_SPI_CS = 1'b0;
        wait_clk(H);
    endtask

    task automatic cs_end();
        wait_clk(H);
        i_SPI_CS = 1'b1;
        wait_clk(2 * H);
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input int n,
                           output logic [2:0][7:0] rxd);
        logic [7:0] rx;
        rxd = '0;
        cs_begin();
        xfer_byte(op, rx);
        if (op == 8'h03) begin
            xfer_byte(addr[23:16], rx);
            xfer_byte(addr[15:8], rx);
            xfer_byte(addr[7:0], rx);
        end
        for (int i = 0; i < n; i++) begin
            xfer_byte(8'h00, rx);
            rxd[i] = rx;
        end
        cs_end();
    endtask

    typedef struct {
        logic [7:0]      op;
        logic [23:0]     addr;
        int              n;
        logic [2:0][7:0] exp;
        int              n_rd;
        logic [15:0]     rd0;
        logic [15:0]     rdl;
        int              n_err;
        logic            oe_on;
    } vec_t;

    vec_t vt [6];

    initial begin
        logic [2:0][7:0] rxd;
        logic r;
        int r0, e0, o0;

        #100ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0][7:0] rxd;
        logic r;
        int r0, e0, o0;

        vt[0] = '{8'h03, 24'h001234, 1, {8'h00, 8'h00, 8'hA5}, 2, 16'h1234, 16'h1235, 0, 1'b1};
        vt[1] = '{8'h03, 24'h000010, 3, {8'h33, 8'h22, 8'h11}, 4, 16'h0010, 16'h0013, 0, 1'b1};
        vt[2] = '{8'h03, 24'hABFFFF, 2, {8'h00, 8'h3C, 8'hC3}, 3, 16'hFFFF, 16'h0001, 0, 1'b1};
        vt[3] = '{8'h05, 24'h000000, 2, {8'h00, 8'h5A, 8'h5A}, 0, 16'h0000, 16'h0000, 0, 1'b1};
        vt[4] = '{8'h9F, 24'h000000, 2, {8'h00, 8'h00, 8'h00}, 0, 16'h0000, 16'h0000, 1, 1'b0};
        vt[5] = '{8'h03, 24'h000011, 2, {8'h00, 8'h33, 8'h22}, 3, 16'h0011, 16'h0013, 0, 1'b1};

        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h1234] = 8'hA5;
        mem[16'h0010] = 8'h11;
        mem[16'h0011] = 8'h22;
        mem[16'h0012] = 8'h33;
        mem[16'hFFFF] = 8'hC3;
        mem[16'h0000] = 8'h3C;

        i_RESET = 1'b1; i_SPI_CS = 1'b1; i_SPI_CLK = 1'b0; i_SPI_MOSI = 1'b0;
        wait_clk(3);
        check("reset_outs", {o_SPI_MISO, o_SPI_MISO_OE, o_MEM_RD, o_BUSY, o_CMD_ERR}, 5'b0);
        check("reset_addr", o_MEM_ADDR, 16'h0000);
        i_RESET = 1'b0;
        wait_clk(5);

        for (int v = 0; v < 6; v++) begin
            r0 = rd_log.size(); e0 = err_cnt; o0 = oe_cnt;
            run_txn(vt[v].op, vt[v].addr, vt[v].n, rxd);
            for (int i = 0; i < vt[v].n; i++)
                check($sformatf("v%0d_byte%0d", v, i), rxd[i], vt[v].exp[i]);
            check($sformatf("v%0d_rd_count", v), rd_log.size() - r0, vt[v].n_rd);
            if (vt[v].n_rd > 0 && rd_log.size() > r0) begin
                check($sformatf("v%0d_rd_first", v), rd_log[r0], vt[v].rd0);
                check($sformatf("v%0d_rd_last", v), rd_log[rd_log.size() - 1], vt[v].rdl);
            end
            check($sformatf("v%0d_cmd_err", v), err_cnt - e0, vt[v].n_err);
            check($sformatf("v%0d_oe_seen", v), oe_cnt > o0, vt[v].oe_on);
            check($sformatf("v%0d_idle_after", v), {o_BUSY, o_SPI_MISO_OE, o_SPI_MISO}, 3'b000);
        end

        // CS rises after 4 data bits, then a fresh read
        cs_begin();
        xfer_byte(8'h03, rxd[0]); xfer_byte(8'h00, rxd[0]);
        xfer_byte(8'h12, rxd[0]); xfer_byte(8'h34, rxd[0]);
        for (int i = 0; i < 4; i++) sck_bit(1'b0, r);
        check("abort_busy_before", o_BUSY, 1'b1);
        i_SPI_CS = 1'b1;
        wait_clk(4);
        check("abort_idle", {o_BUSY, o_SPI_MISO_OE, o_SPI_MISO}, 3'b000);
        wait_clk(2 * H);
        run_txn(8'h03, 24'h000012, 1, rxd);
        check("after_abort_byte", rxd[0], 8'h33);

        // Fewer than 8 command clocks: no error pulse
        e0 = err_cnt;
        cs_begin();
        for (int i = 0; i < 3; i++) sck_bit(1'b1, r);
        cs_end();
        check("short_cs_err", err_cnt - e0, 0);
        check("short_cs_busy", o_BUSY, 1'b0);

        // Asynchronous reset in the middle of the address phase
        cs_begin();
        xfer_byte(8'h03, rxd[0]); xfer_byte(8'h00, rxd[0]);
        sck_bit(1'b1, r);
        check("pre_reset_busy", o_BUSY, 1'b1);
        i_RESET = 1'b1;
        #1;
        check("midreset_outs", {o_SPI_MISO, o_SPI_MISO_OE, o_MEM_RD, o_BUSY, o_CMD_ERR}, 5'b0);
        check("midreset_addr", o_MEM_ADDR, 16'h0000);
        i_SPI_CS = 1'b1;
        wait_clk(4);
        i_RESET = 1'b0;
        wait_clk(4);
        run_txn(8'h03, 24'h001234, 1, rxd);
        check("post_reset_byte", rxd[0], 8'hA5);

        check("no_back_to_back_rd", double_rd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
